// File: rtl/hd44780_bus_driver_if.sv
// Upstream byte handshake plus the LCD pin bundle of the HD44780 bus driver.
interface hd44780_bus_driver_if;
    logic       i_valid;
    logic       i_rs;
    logic [7:0] i_d;
    logic       o_ready;
    logic       o_lcd_rs;
    logic       o_lcd_rw;
    logic       o_lcd_e;
    logic [7:0] o_lcd_d;

    modport master (
        output i_valid, i_rs, i_d,
        input  o_ready, o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_d
    );

    modport slave (
        input  i_valid, i_rs, i_d,
        output o_ready, o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_d
    );
endinterface

// File: rtl/hd44780_bus_driver.sv
// HD44780 write-only bus driver: power-on delay, then one timed E strobe per accepted byte.
// Define HD44780_4BIT_EN for a 4-bit bus (high then low nibble strobed on DB7..DB4).
module hd44780_bus_driver #(
    parameter int T_POWERUP = 1_500_000,
    parameter int T_SETUP   = 4,
    parameter int T_EN      = 25,
    parameter int T_HOLD    = 2,
    parameter int T_EXEC    = 3_700,
    parameter int T_CLEAR   = 152_000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    hd44780_bus_driver_if.slave bus
);
    function automatic int eff(input int t);
        return (t < 1) ? 1 : t;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(eff(T_POWERUP), eff(T_SETUP)),
                                     max2(eff(T_EN), eff(T_HOLD))),
                                max2(eff(T_EXEC), eff(T_CLEAR)));
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // A state lasting N cycles loads N-1 on entry and leaves when the count hits zero.
    function automatic logic [CNT_W-1:0] reload(input int t);
        return CNT_W'(eff(t) - 1);
    endfunction

    localparam logic [CNT_W-1:0] LD_POWERUP = reload(T_POWERUP);
    localparam logic [CNT_W-1:0] LD_SETUP   = reload(T_SETUP);
    localparam logic [CNT_W-1:0] LD_EN      = reload(T_EN);
    localparam logic [CNT_W-1:0] LD_HOLD    = reload(T_HOLD);
    localparam logic [CNT_W-1:0] LD_EXEC    = reload(T_EXEC);
    localparam logic [CNT_W-1:0] LD_CLEAR   = reload(T_CLEAR);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_IDLE,
        S_SETUP,
        S_EN_HIGH,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [7:0]       byte_q, byte_d;
    logic [7:0]       lcd_db_q, lcd_db_d;
    logic [CNT_W-1:0] wait_ld;
    logic             cnt_zero;
`ifdef HD44780_4BIT_EN
    logic             nib_lo_q, nib_lo_d;
`endif

    function automatic logic [7:0] first_word(input logic [7:0] b);
`ifdef HD44780_4BIT_EN
        return {b[7:4], 4'h0};
`else
        return b;
`endif
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs_d     = rs_q;
        byte_d   = byte_q;
        lcd_db_d = lcd_db_q;
`ifdef HD44780_4BIT_EN
        nib_lo_d = nib_lo_q;
`endif
        cnt_zero = (cnt_q == '0);
        // Clear and Return Home need the long execution time.
        wait_ld  = (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02)) ? LD_CLEAR : LD_EXEC;

        case (state_q)
            // Reset leaves the counter at zero, so power-up counts upward to its limit.
            S_POWERUP: begin
                if (cnt_q == LD_POWERUP) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.i_valid) begin
                    rs_d     = bus.i_rs;
                    byte_d   = bus.i_d;
                    lcd_db_d = first_word(bus.i_d);
                    state_d  = S_SETUP;
                    cnt_d    = LD_SETUP;
`ifdef HD44780_4BIT_EN
                    nib_lo_d = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_EN_HIGH;
                    cnt_d   = LD_EN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EN_HIGH: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
`ifdef HD44780_4BIT_EN
                    if (!nib_lo_q) begin
                        nib_lo_d = 1'b1;
                        lcd_db_d = {byte_q[3:0], 4'h0};
                        state_d  = S_SETUP;
                        cnt_d    = LD_SETUP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = wait_ld;
                    end
`else
                    state_d = S_WAIT;
                    cnt_d   = wait_ld;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_POWERUP;
                cnt_d   = '0;
            end
        endcase

        // Strobe and ready are decoded from the next state so both leave flops cleanly.
        ready_d = (state_d == S_IDLE);
        e_d     = (state_d == S_EN_HIGH);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_POWERUP;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            byte_q   <= 8'h00;
            lcd_db_q <= 8'h00;
`ifdef HD44780_4BIT_EN
            nib_lo_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            byte_q   <= byte_d;
            lcd_db_q <= lcd_db_d;
`ifdef HD44780_4BIT_EN
            nib_lo_q <= nib_lo_d;
`endif
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_lcd_rs = rs_q;
    assign bus.o_lcd_rw = 1'b0;
    assign bus.o_lcd_e  = e_q;
    assign bus.o_lcd_d  = lcd_db_q;
endmodule

// File: tb/tb_hd44780_bus_driver.sv
// Directed bench for hd44780_bus_driver with shortened power-up and execution delays.
module tb_hd44780_bus_driver;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    hd44780_bus_driver_if bus ();

    hd44780_bus_driver #(
        .T_POWERUP(20),
        .T_SETUP  (4),
        .T_EN     (25),
        .T_HOLD   (2),
        .T_EXEC   (50),
        .T_CLEAR  (200)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor: counts rising edges, records the bus at each rise, flags odd widths.
    int         pulses = 0;
    int         bad_w  = 0;
    int         w      = 0;
    logic       e_prev = 1'b0;
    logic [8:0] cap [$];

    always @(negedge clk) begin
        if (bus.o_lcd_e && !e_prev) begin
            pulses++;
            cap.push_back({bus.o_lcd_rs, bus.o_lcd_d});
        end
        if (bus.o_lcd_e) begin
            w++;
        end else if (e_prev) begin
            if (w != 25) bad_w++;
            w = 0;
        end
        e_prev = bus.o_lcd_e;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Release reset on a negedge and count samples until ready rises; pins must stay low.
    task automatic powerup(input string tag);
        int   n;
        logic pins_bad;
        n        = 0;
        pins_bad = 1'b0;
        rst_n    = 1'b1;
        while (!bus.o_ready && n < 1000) begin
            if (bus.o_lcd_e || bus.o_lcd_rs || bus.o_lcd_rw || bus.o_lcd_d != 8'h00) pins_bad = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({tag, "_ready_low_cycles"}, n, 20);
        chk({tag, "_pins_zero"}, 32'(pins_bad), 32'd0);
    endtask

`ifndef HD44780_4BIT_EN
    // One 8-bit transfer starting at a negedge with ready high; post counts HOLD+WAIT samples.
    task automatic xfer(input logic rs, input logic [7:0] d, input int post, input string tag);
        int   n;
        logic en_bad;
        chk({tag, "_ready_before"}, 32'(bus.o_ready), 32'd1);
        bus.i_valid = 1'b1;
        bus.i_rs    = rs;
        bus.i_d     = d;
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_rs    = ~rs;
        bus.i_d     = ~d;
        chk({tag, "_ready_after_accept"}, 32'(bus.o_ready), 32'd0);
        chk({tag, "_rs"}, 32'(bus.o_lcd_rs), 32'(rs));
        chk({tag, "_d"}, 32'(bus.o_lcd_d), 32'(d));
        n = 0;
        while (!bus.o_lcd_e && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_setup_cycles"}, n, 4);
        n      = 0;
        en_bad = 1'b0;
        while (bus.o_lcd_e && n < 1000) begin
            if (bus.o_lcd_d != d || bus.o_lcd_rs != rs) en_bad = 1'b1;
            bus.i_valid = n[0];
            bus.i_d     = 8'(n);
            n++;
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        chk({tag, "_en_cycles"}, n, 25);
        chk({tag, "_bus_stable_in_e"}, 32'(en_bad), 32'd0);
        chk({tag, "_hold_d"}, 32'(bus.o_lcd_d), 32'(d));
        n = 0;
        while (!bus.o_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_hold_plus_wait"}, n, post);
        chk({tag, "_d_kept_idle"}, 32'({bus.o_lcd_rs, bus.o_lcd_d}), 32'({rs, d}));
    endtask
`endif

    initial begin
        int         n;
        int         base;
        int         p0;
        int         idx;
        logic [7:0] seq [3];

        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_rs    = 1'b0;
        bus.i_d     = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.o_ready), 32'd0);
        chk("rst_e", 32'(bus.o_lcd_e), 32'd0);
        chk("rst_rs", 32'(bus.o_lcd_rs), 32'd0);
        chk("rst_rw", 32'(bus.o_lcd_rw), 32'd0);
        chk("rst_d", 32'(bus.o_lcd_d), 32'd0);

        powerup("pu1");
        chk("pu1_no_pulses", pulses, 0);

`ifdef HD44780_4BIT_EN
        bus.i_valid = 1'b1;
        bus.i_rs    = 1'b1;
        bus.i_d     = 8'h4D;
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_d     = 8'hFF;
        chk("n4_hi_d", 32'(bus.o_lcd_d), 32'h40);
        chk("n4_rs", 32'(bus.o_lcd_rs), 32'd1);
        n = 0;
        while (!bus.o_lcd_e && n < 1000) begin n++; @(negedge clk); end
        chk("n4_setup_hi", n, 4);
        n = 0;
        while (bus.o_lcd_e && n < 1000) begin n++; @(negedge clk); end
        chk("n4_en_hi", n, 25);
        chk("n4_hold_hi_d", 32'(bus.o_lcd_d), 32'h40);
        n = 0;
        while (!bus.o_lcd_e && n < 1000) begin n++; @(negedge clk); end
        chk("n4_gap", n, 6);
        chk("n4_lo_d", 32'(bus.o_lcd_d), 32'hD0);
        n = 0;
        while (bus.o_lcd_e && n < 1000) begin n++; @(negedge clk); end
        chk("n4_en_lo", n, 25);
        n = 0;
        while (!bus.o_ready && n < 5000) begin n++; @(negedge clk); end
        chk("n4_hold_plus_wait", n, 52);
        chk("n4_pulses", pulses, 2);
        chk("n4_cap0", 32'(cap[0]), 32'h140);
        chk("n4_cap1", 32'(cap[1]), 32'h1D0);
`else
        xfer(1'b1, 8'h35, 52, "data35");
        xfer(1'b0, 8'h01, 202, "clear");
        xfer(1'b1, 8'h01, 52, "data01");
        xfer(1'b0, 8'h02, 202, "home");
        xfer(1'b0, 8'h03, 52, "cmd03");
        chk("pulses_after_singles", pulses, 5);

        // Three bytes offered back to back with i_valid held high throughout.
        seq[0]      = 8'hA1;
        seq[1]      = 8'h5C;
        seq[2]      = 8'h0F;
        base        = cap.size();
        p0          = pulses;
        idx         = 0;
        bus.i_valid = 1'b1;
        bus.i_rs    = 1'b1;
        bus.i_d     = seq[0];
        for (int c = 0; c < 2000 && !(idx == 3 && bus.o_ready); c++) begin
            if (bus.o_ready && idx < 3) begin
                @(negedge clk);
                idx++;
                if (idx < 3) bus.i_d = seq[idx];
                else bus.i_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        bus.i_valid = 1'b0;
        chk("b2b_pulses", pulses - p0, 3);
        chk("b2b_byte0", 32'(cap[base]), 32'({1'b1, seq[0]}));
        chk("b2b_byte1", 32'(cap[base+1]), 32'({1'b1, seq[1]}));
        chk("b2b_byte2", 32'(cap[base+2]), 32'({1'b1, seq[2]}));
        chk("e_width_all_25", bad_w, 0);

        // Reset asserted in the middle of the enable pulse.
        bus.i_valid = 1'b1;
        bus.i_rs    = 1'b1;
        bus.i_d     = 8'h77;
        @(negedge clk);
        bus.i_valid = 1'b0;
        n = 0;
        while (!bus.o_lcd_e && n < 1000) begin n++; @(negedge clk); end
        chk("rst_mid_e_seen", 32'(bus.o_lcd_e), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_e_low", 32'(bus.o_lcd_e), 32'd0);
        chk("rst_mid_ready", 32'(bus.o_ready), 32'd0);
        chk("rst_mid_d", 32'(bus.o_lcd_d), 32'd0);
        p0 = pulses;
        @(negedge clk);
        @(negedge clk);
        powerup("pu2");
        repeat (10) @(negedge clk);
        chk("pu2_no_e", pulses - p0, 0);
        chk("pu2_ready", 32'(bus.o_ready), 32'd1);
        chk("pu2_dropped", 32'({bus.o_lcd_rs, bus.o_lcd_d}), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
